// File: rtl/mod_ctrl_pkg.sv
// Shared constants and FSM state type for the arbitrated remainder unit.
package mod_ctrl_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned ITER_W   = 4;
    localparam int unsigned NUM_ITER = DATA_W;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/mod_iter_core.sv
// Restoring-division datapath: one iteration per step, dividend MSB first.
// Optional quotient register when MOD_QUOTIENT_EN is defined.
module mod_iter_core
    import mod_ctrl_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
`ifdef MOD_QUOTIENT_EN
    output logic [DATA_W-1:0] quot_o,
`endif
    output logic [DATA_W-1:0] rem_o
);

    logic [DATA_W-1:0] dvd_q;
    logic [DATA_W-1:0] dvs_q;
    logic [DATA_W:0]   rem_q;
    logic [DATA_W+1:0] rem_shift;
    logic [DATA_W:0]   rem_next;
    logic              ge;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_shift = {rem_q, dvd_q[DATA_W-1]};
        ge        = (rem_shift >= {2'b00, dvs_q});
        rem_next  = rem_shift[DATA_W:0] - (ge ? {1'b0, dvs_q} : '0);
    end

    // Operand and remainder registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dvd_q <= '0;
            dvs_q <= '0;
            rem_q <= '0;
        end else if (load_i) begin
            dvd_q <= a_i;
            dvs_q <= b_i;
            rem_q <= '0;
        end else if (step_i) begin
            dvd_q <= {dvd_q[DATA_W-2:0], 1'b0};
            rem_q <= rem_next;
        end
    end

    assign rem_o = rem_q[DATA_W-1:0];

`ifdef MOD_QUOTIENT_EN
    logic [DATA_W-1:0] quot_q;

    // Quotient bits shift in LSB-last, one per step.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            quot_q <= '0;
        end else if (load_i) begin
            quot_q <= '0;
        end else if (step_i) begin
            quot_q <= {quot_q[DATA_W-2:0], ge};
        end
    end

    assign quot_o = quot_q;
`endif

endmodule

// File: rtl/mod_arbiter_ctrl.sv
// Two-requester round-robin front end for a serial remainder unit.
// Define MOD_QUOTIENT_EN to also expose the quotient on rsp_quot_o.
module mod_arbiter_ctrl
    import mod_ctrl_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req0_valid_i,
    input  logic [DATA_W-1:0] req0_a_i,
    input  logic [DATA_W-1:0] req0_b_i,
    output logic              req0_ready_o,
    input  logic              req1_valid_i,
    input  logic [DATA_W-1:0] req1_a_i,
    input  logic [DATA_W-1:0] req1_b_i,
    output logic              req1_ready_o,
    output logic              rsp_valid_o,
    output logic              rsp_id_o,
    output logic [DATA_W-1:0] rsp_result_o,
    input  logic              rsp_ready_i,
`ifdef MOD_QUOTIENT_EN
    output logic [DATA_W-1:0] rsp_quot_o,
`endif
    output logic              busy_o
);

    state_e            state_q, state_d;
    logic              prio_q, prio_d;   // requester favoured on a tie
    logic              id_q, id_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic              any_valid;
    logic              grant_id;
    logic [DATA_W-1:0] sel_a, sel_b;
    logic              zero_op;
    logic              load, step;

    // Round-robin pick and operand mux.
    always_comb begin
        any_valid = req0_valid_i | req1_valid_i;
        if (req0_valid_i && req1_valid_i) begin
            grant_id = prio_q;
        end else begin
            grant_id = req1_valid_i;
        end
        sel_a   = grant_id ? req1_a_i : req0_a_i;
        sel_b   = grant_id ? req1_b_i : req0_b_i;
        zero_op = (sel_a == '0) || (sel_b == '0);
    end

    // Next-state, grant and datapath control.
    always_comb begin
        state_d      = state_q;
        prio_d       = prio_q;
        id_d         = id_q;
        iter_d       = iter_q;
        load         = 1'b0;
        step         = 1'b0;
        req0_ready_o = 1'b0;
        req1_ready_o = 1'b0;
        case (state_q)
            StIdle: begin
                // rst_ni gating keeps ready low while reset is held.
                if (any_valid && rst_ni) begin
                    load         = 1'b1;
                    id_d         = grant_id;
                    prio_d       = ~grant_id;
                    iter_d       = '0;
                    req0_ready_o = ~grant_id;
                    req1_ready_o = grant_id;
                    state_d      = zero_op ? StDone : StCalc;
                end
            end
            StCalc: begin
                step = 1'b1;
                if (iter_q == ITER_W'(NUM_ITER - 1)) begin
                    iter_d  = '0;
                    state_d = StDone;
                end else begin
                    iter_d = iter_q + 1'b1;
                end
            end
            StDone: begin
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            prio_q  <= 1'b0;
            id_q    <= 1'b0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            id_q    <= id_d;
            iter_q  <= iter_d;
        end
    end

    mod_iter_core u_core (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (load),
        .step_i (step),
        .a_i    (sel_a),
        .b_i    (sel_b),
`ifdef MOD_QUOTIENT_EN
        .quot_o (rsp_quot_o),
`endif
        .rem_o  (rsp_result_o)
    );

    assign rsp_valid_o = (state_q == StDone);
    assign rsp_id_o    = id_q;
    assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_mod_arbiter_ctrl.sv
// Self-checking bench for mod_arbiter_ctrl; reference model uses plain % and /
// and a round-robin pointer kept at transaction level.
`timescale 1ns/1ps
module tb_mod_arbiter_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       req0_valid_i, req1_valid_i;
    logic [7:0] req0_a_i, req0_b_i, req1_a_i, req1_b_i;
    logic       req0_ready_o, req1_ready_o;
    logic       rsp_valid_o, rsp_id_o, rsp_ready_i, busy_o;
    logic [7:0] rsp_result_o;
`ifdef MOD_QUOTIENT_EN
    logic [7:0] rsp_quot_o;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit ptr_m;  // model: requester favoured on a tie

    mod_arbiter_ctrl dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req0_valid_i (req0_valid_i),
        .req0_a_i     (req0_a_i),
        .req0_b_i     (req0_b_i),
        .req0_ready_o (req0_ready_o),
        .req1_valid_i (req1_valid_i),
        .req1_a_i     (req1_a_i),
        .req1_b_i     (req1_b_i),
        .req1_ready_o (req1_ready_o),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_id_o     (rsp_id_o),
        .rsp_result_o (rsp_result_o),
        .rsp_ready_i  (rsp_ready_i),
`ifdef MOD_QUOTIENT_EN
        .rsp_quot_o   (rsp_quot_o),
`endif
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic bit pred_grant(bit v0, bit v1);
        if (v0 && v1) return ptr_m;
        return v1;
    endfunction

    function automatic logic [7:0] exp_rem(logic [7:0] a, logic [7:0] b);
        if (a == 8'd0 || b == 8'd0) return 8'd0;
        return a % b;
    endfunction

    function automatic logic [7:0] exp_quot(logic [7:0] a, logic [7:0] b);
        if (a == 8'd0 || b == 8'd0) return 8'd0;
        return a / b;
    endfunction

    function automatic int exp_lat(logic [7:0] a, logic [7:0] b);
        return (a == 8'd0 || b == 8'd0) ? 1 : 9;
    endfunction

    // From a negedge with inputs applied: watch ready until a grant; returns at the
    // negedge after the accept edge. gid 2 means both readies were high.
    task automatic wait_grant(output int gid, output bit timed_out);
        gid = -1;
        timed_out = 1'b1;
        for (int i = 0; i < 64; i++) begin
            #1;
            if (req0_ready_o && req1_ready_o) gid = 2;
            else if (req0_ready_o) gid = 0;
            else if (req1_ready_o) gid = 1;
            @(negedge clk_i);
            if (gid >= 0) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    // Cycles after the accept cycle until rsp_valid_o is seen; returns at negedge+1.
    task automatic wait_rsp(output int lat, output bit timed_out);
        lat = 1;
        timed_out = 1'b1;
        for (int i = 0; i < 64; i++) begin
            #1;
            if (rsp_valid_o) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clk_i);
            lat++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        ptr_m  = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        ptr_m = 1'b0;
        req0_valid_i = 1'b1;
        req1_valid_i = 1'b1;
        #1;
        total_cnt++;
        if ({req0_ready_o, req1_ready_o, rsp_valid_o, rsp_id_o, busy_o} !== 5'b0)
            $display("FAIL reset_ctrl: got %b want 00000",
                     {req0_ready_o, req1_ready_o, rsp_valid_o, rsp_id_o, busy_o});
        else pass_cnt++;
        total_cnt++;
        if (rsp_result_o !== 8'd0) $display("FAIL reset_result: got %0d want 0", rsp_result_o);
        else pass_cnt++;
`ifdef MOD_QUOTIENT_EN
        total_cnt++;
        if (rsp_quot_o !== 8'd0) $display("FAIL reset_quot: got %0d want 0", rsp_quot_o);
        else pass_cnt++;
`endif
        @(negedge clk_i);
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        rst_ni = 1'b1;
        #1;
        total_cnt++;
        if (busy_o !== 1'b0) $display("FAIL reset_idle_busy: got %b want 0", busy_o);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        int gid, lat;
        bit to;
        @(negedge clk_i);
        req0_a_i = 8'd200;
        req0_b_i = 8'd7;
        req0_valid_i = 1'b1;
        rsp_ready_i = 1'b1;
        wait_grant(gid, to);
        req0_valid_i = 1'b0;
        total_cnt++;
        if (to || gid !== 0) $display("FAIL basic_grant: got %0d (timeout %0d) want 0", gid, to);
        else pass_cnt++;
        ptr_m = 1'b1;
        #1;
        total_cnt++;
        if ({busy_o, rsp_valid_o} !== 2'b10)
            $display("FAIL basic_calc: busy/valid got %b want 10", {busy_o, rsp_valid_o});
        else pass_cnt++;
        wait_rsp(lat, to);
        total_cnt++;
        if (to || lat !== 9) $display("FAIL basic_latency: got %0d (timeout %0d) want 9", lat, to);
        else pass_cnt++;
        total_cnt++;
        if (rsp_result_o !== 8'd4 || rsp_id_o !== 1'b0)
            $display("FAIL basic_result: got %0d id %0d want 4 id 0", rsp_result_o, rsp_id_o);
        else pass_cnt++;
`ifdef MOD_QUOTIENT_EN
        total_cnt++;
        if (rsp_quot_o !== 8'd28) $display("FAIL basic_quot: got %0d want 28", rsp_quot_o);
        else pass_cnt++;
`endif
        @(negedge clk_i);
        #1;
        total_cnt++;
        if ({busy_o, rsp_valid_o} !== 2'b00)
            $display("FAIL basic_release: busy/valid got %b want 00", {busy_o, rsp_valid_o});
        else pass_cnt++;
    endtask

    task automatic test_zero_operand();
        logic [7:0] ta[2] = '{8'd5, 8'd0};
        logic [7:0] tb[2] = '{8'd0, 8'd9};
        int gid, lat;
        bit to;
        bit id;
        rsp_ready_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            id = (k == 0);
            @(negedge clk_i);
            req0_a_i = ta[k];
            req0_b_i = tb[k];
            req1_a_i = ta[k];
            req1_b_i = tb[k];
            req0_valid_i = ~id;
            req1_valid_i = id;
            wait_grant(gid, to);
            req0_valid_i = 1'b0;
            req1_valid_i = 1'b0;
            total_cnt++;
            if (to || gid !== int'(id)) $display("FAIL zero_grant: got %0d want %0d", gid, id);
            else pass_cnt++;
            ptr_m = ~id;
            wait_rsp(lat, to);
            total_cnt++;
            if (to || lat !== 1) $display("FAIL zero_latency: got %0d want 1", lat);
            else pass_cnt++;
            total_cnt++;
            if (rsp_result_o !== 8'd0 || rsp_id_o !== id)
                $display("FAIL zero_result: got %0d id %0d want 0 id %0d",
                         rsp_result_o, rsp_id_o, id);
            else pass_cnt++;
`ifdef MOD_QUOTIENT_EN
            total_cnt++;
            if (rsp_quot_o !== 8'd0) $display("FAIL zero_quot: got %0d want 0", rsp_quot_o);
            else pass_cnt++;
`endif
            @(negedge clk_i);
        end
    endtask

    task automatic test_alternate();
        int gid, lat;
        bit to;
        bit e;
        do_reset();
        req0_a_i = 8'd255;
        req0_b_i = 8'd1;
        req1_a_i = 8'd5;
        req1_b_i = 8'd200;
        req0_valid_i = 1'b1;
        req1_valid_i = 1'b1;
        rsp_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            e = pred_grant(1'b1, 1'b1);
            wait_grant(gid, to);
            total_cnt++;
            if (to || gid !== int'(e)) $display("FAIL alt_grant%0d: got %0d want %0d", k, gid, e);
            else pass_cnt++;
            ptr_m = ~e;
            wait_rsp(lat, to);
            total_cnt++;
            if (to || rsp_id_o !== e || rsp_result_o !== (e ? 8'd5 : 8'd0))
                $display("FAIL alt_result%0d: got %0d id %0d want %0d id %0d",
                         k, rsp_result_o, rsp_id_o, (e ? 5 : 0), e);
            else pass_cnt++;
            total_cnt++;
            if ({req0_ready_o, req1_ready_o} !== 2'b00)
                $display("FAIL alt_done_ready%0d: got %b want 00", k, {req0_ready_o, req1_ready_o});
            else pass_cnt++;
            @(negedge clk_i);
        end
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
    endtask

    task automatic test_backpressure();
        int gid, lat;
        bit to;
        bit e;
        logic [7:0] er;
        @(negedge clk_i);
        req0_a_i = 8'd100;
        req0_b_i = 8'd9;
        req1_a_i = 8'd77;
        req1_b_i = 8'd13;
        req0_valid_i = 1'b1;
        req1_valid_i = 1'b1;
        rsp_ready_i = 1'b0;
        e = pred_grant(1'b1, 1'b1);
        er = e ? exp_rem(8'd77, 8'd13) : exp_rem(8'd100, 8'd9);
        wait_grant(gid, to);
        if (gid == 0) req0_valid_i = 1'b0;
        if (gid == 1) req1_valid_i = 1'b0;
        total_cnt++;
        if (to || gid !== int'(e)) $display("FAIL bp_grant: got %0d want %0d", gid, e);
        else pass_cnt++;
        ptr_m = ~e;
        wait_rsp(lat, to);
        total_cnt++;
        if (to || rsp_result_o !== er || rsp_id_o !== e)
            $display("FAIL bp_result: got %0d id %0d want %0d id %0d", rsp_result_o, rsp_id_o, er, e);
        else pass_cnt++;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_i);
            #1;
            total_cnt++;
            if ({rsp_valid_o, rsp_id_o, rsp_result_o, req0_ready_o, req1_ready_o}
                !== {1'b1, e, er, 2'b00})
                $display("FAIL bp_hold%0d: valid %b id %b res %0d ready %b%b", c,
                         rsp_valid_o, rsp_id_o, rsp_result_o, req0_ready_o, req1_ready_o);
            else pass_cnt++;
        end
        rsp_ready_i = 1'b1;
        e = ~e;
        er = e ? exp_rem(8'd77, 8'd13) : exp_rem(8'd100, 8'd9);
        wait_grant(gid, to);
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        total_cnt++;
        if (to || gid !== int'(e)) $display("FAIL bp_next_grant: got %0d want %0d", gid, e);
        else pass_cnt++;
        ptr_m = ~e;
        wait_rsp(lat, to);
        total_cnt++;
        if (to || rsp_result_o !== er)
            $display("FAIL bp_next_result: got %0d want %0d", rsp_result_o, er);
        else pass_cnt++;
        @(negedge clk_i);
    endtask

    task automatic test_reset_mid_calc();
        int gid, lat;
        bit to;
        bit seen;
        do_reset();
        @(negedge clk_i);
        req0_a_i = 8'd200;
        req0_b_i = 8'd7;
        req0_valid_i = 1'b1;
        rsp_ready_i = 1'b1;
        wait_grant(gid, to);
        req0_valid_i = 1'b0;
        ptr_m = 1'b1;
        repeat (4) @(negedge clk_i);
        rst_ni = 1'b0;
        ptr_m = 1'b0;
        #1;
        total_cnt++;
        if ({busy_o, rsp_valid_o} !== 2'b00)
            $display("FAIL abort_state: busy/valid got %b want 00", {busy_o, rsp_valid_o});
        else pass_cnt++;
        @(negedge clk_i);
        rst_ni = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (rsp_valid_o) seen = 1'b1;
            @(negedge clk_i);
        end
        total_cnt++;
        if (seen) $display("FAIL abort_no_rsp: rsp_valid_o seen 1 want 0");
        else pass_cnt++;
        req0_a_i = 8'd10;
        req0_b_i = 8'd3;
        req1_a_i = 8'd9;
        req1_b_i = 8'd4;
        req0_valid_i = 1'b1;
        req1_valid_i = 1'b1;
        wait_grant(gid, to);
        req0_valid_i = 1'b0;
        total_cnt++;
        if (to || gid !== int'(pred_grant(1'b1, 1'b1)))
            $display("FAIL abort_regrant: got %0d want 0", gid);
        else pass_cnt++;
        ptr_m = 1'b1;
        wait_rsp(lat, to);
        total_cnt++;
        if (to || rsp_result_o !== 8'd1 || rsp_id_o !== 1'b0)
            $display("FAIL abort_result: got %0d id %0d want 1 id 0", rsp_result_o, rsp_id_o);
        else pass_cnt++;
        wait_grant(gid, to);
        req1_valid_i = 1'b0;
        ptr_m = 1'b0;
        wait_rsp(lat, to);
        @(negedge clk_i);
    endtask

    task automatic test_random();
        bit         pv[2];
        logic [7:0] pa[2], pb[2];
        int gid, lat, k;
        bit to;
        bit e;
        pv[0] = 1'b0;
        pv[1] = 1'b0;
        for (int t = 0; t < 40; t++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pv[r] && $urandom_range(0, 1) == 1) begin
                    pv[r] = 1'b1;
                    pa[r] = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
                    pb[r] = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
                end
            end
            if (!pv[0] && !pv[1]) begin
                pv[0] = 1'b1;
                pa[0] = 8'($urandom_range(0, 255));
                pb[0] = 8'($urandom_range(1, 255));
            end
            req0_valid_i = pv[0];
            req0_a_i = pa[0];
            req0_b_i = pb[0];
            req1_valid_i = pv[1];
            req1_a_i = pa[1];
            req1_b_i = pb[1];
            rsp_ready_i = 1'b0;
            e = pred_grant(pv[0], pv[1]);
            wait_grant(gid, to);
            total_cnt++;
            if (to || gid !== int'(e)) begin
                $display("FAIL rand_grant%0d: got %0d want %0d", t, gid, e);
                return;
            end else pass_cnt++;
            ptr_m = ~e;
            pv[e] = 1'b0;
            if (e) req1_valid_i = 1'b0;
            else req0_valid_i = 1'b0;
            wait_rsp(lat, to);
            total_cnt++;
            if (to || lat !== exp_lat(pa[e], pb[e]))
                $display("FAIL rand_latency%0d: got %0d want %0d", t, lat, exp_lat(pa[e], pb[e]));
            else pass_cnt++;
            total_cnt++;
            if (rsp_result_o !== exp_rem(pa[e], pb[e]) || rsp_id_o !== e)
                $display("FAIL rand_result%0d: %0d%%%0d got %0d id %0d want %0d id %0d", t,
                         pa[e], pb[e], rsp_result_o, rsp_id_o, exp_rem(pa[e], pb[e]), e);
            else pass_cnt++;
`ifdef MOD_QUOTIENT_EN
            total_cnt++;
            if (rsp_quot_o !== exp_quot(pa[e], pb[e]))
                $display("FAIL rand_quot%0d: got %0d want %0d", t, rsp_quot_o,
                         exp_quot(pa[e], pb[e]));
            else pass_cnt++;
`endif
            k = $urandom_range(0, 3);
            for (int c = 0; c < k; c++) begin
                @(negedge clk_i);
                #1;
                total_cnt++;
                if (!rsp_valid_o || rsp_result_o !== exp_rem(pa[e], pb[e]) || req0_ready_o
                    || req1_ready_o)
                    $display("FAIL rand_hold%0d: valid %b res %0d ready %b%b", t, rsp_valid_o,
                             rsp_result_o, req0_ready_o, req1_ready_o);
                else pass_cnt++;
            end
            rsp_ready_i = 1'b1;
            @(negedge clk_i);
        end
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        if (pv[0] || pv[1]) begin
            // Drain the leftover pending request so the pointer model stays aligned.
            e = pred_grant(pv[0], pv[1]);
            req0_valid_i = pv[0];
            req1_valid_i = pv[1];
            wait_grant(gid, to);
            req0_valid_i = 1'b0;
            req1_valid_i = 1'b0;
            ptr_m = ~e;
            wait_rsp(lat, to);
            @(negedge clk_i);
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        req0_a_i = '0;
        req0_b_i = '0;
        req1_a_i = '0;
        req1_b_i = '0;
        rsp_ready_i = 1'b0;
        ptr_m = 1'b0;
        test_reset();
        test_basic();
        test_zero_operand();
        test_alternate();
        test_backpressure();
        test_reset_mid_calc();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far",
                 pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule

// File: doc/mod_arbiter_ctrl.md
MOD_ARBITER_CTRL -- requirements
Module: mod_arbiter_ctrl

Interface
REQ-001 SHALL have ports, one per line: name  direction  width  meaning:
  clk_i  input  1  single clock, all state on rising edge
  rst_ni  input  1  reset, asynchronous, active-low
  req0_valid_i  input  1  requester 0 operand pair valid
  req0_a_i  input  8  requester 0 dividend
  req0_b_i  input  8  requester 0 divisor
  req0_ready_o  output  1  requester 0 accepted this cycle
  req1_valid_i  input  1  requester 1 operand pair valid
  req1_a_i  input  8  requester 1 dividend
  req1_b_i  input  8  requester 1 divisor
  req1_ready_o  output  1  requester 1 accepted this cycle
  rsp_valid_o  output  1  result valid
  rsp_id_o  output  1  requester index owning the result
  rsp_result_o  output  8  remainder a % b
  rsp_ready_i  input  1  consumer takes result
  busy_o  output  1  high in any state other than IDLE
REQ-002 SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-003 SHALL implement FSM states IDLE, CALC, DONE.
REQ-004 In IDLE, if any reqN_valid_i is high, SHALL grant exactly one requester, assert only its reqN_ready_o combinationally in that cycle, latch its a/b and index, and leave IDLE on the next edge.
REQ-005 Arbitration SHALL be round-robin: a priority pointer selects the favoured requester; after every grant the pointer moves to the non-granted requester; a single valid requester is always granted.
REQ-006 reqN_ready_o SHALL be 0 in CALC and DONE; valid requests SHALL remain pending, never dropped.
REQ-007 If the latched a == 0 or b == 0, SHALL go IDLE -> DONE with result 8'd0, skipping CALC.
REQ-008 Otherwise SHALL go IDLE -> CALC and perform 8 restoring-division iterations, one per cycle, MSB of a first: rem = {rem, next a bit}; if rem >= b then rem -= b; remainder register 9 bits wide.
REQ-009 After the 8th CALC cycle SHALL go to DONE; rsp_result_o SHALL equal a % b (unsigned, 8-bit).
REQ-010 Latency SHALL be accept edge + 9 cycles to rsp_valid_o for nonzero operands, accept edge + 1 cycle for a zero operand.
REQ-011 In DONE, rsp_valid_o, rsp_id_o, rsp_result_o SHALL stay constant until rsp_ready_i is high; on that edge, SHALL go to IDLE.
REQ-012 No new grant SHALL occur in the cycle DONE is left; the earliest next grant is the following IDLE cycle.
REQ-013 rsp_valid_o SHALL be 0 in IDLE and CALC.

Reset
REQ-014 rst_ni low SHALL immediately force IDLE, pointer favouring requester 0, iteration counter 0, rsp_valid_o 0, rsp_id_o 0, rsp_result_o 0, reqN_ready_o 0, busy_o 0.
REQ-015 Reset during CALC or DONE SHALL abort the operation with no response produced.

Configuration
REQ-016 With MOD_QUOTIENT_EN defined, SHALL add output rsp_quot_o (8 bits, a / b; 0 when a or b is 0), held with rsp_result_o and reset to 0.
REQ-017 Without MOD_QUOTIENT_EN, the port and quotient register SHALL be absent; remainder behaviour is unchanged.

Structure
REQ-018 A shared package mod_ctrl_pkg SHALL hold DATA_W = 8, ITER_W = 4, and the FSM state enum.
REQ-019 The iteration datapath SHALL be a sub-module mod_iter_core (load, step, remainder and quotient out); arbitration and FSM stay in mod_arbiter_ctrl.

Verification
REQ-020 The bench SHALL cover these scenarios:
  req0 a=200 b=7, rsp_ready_i=1 -> rsp_valid_o 9 cycles after accept, result 4, id 0
  req1 a=5 b=0 -> result 0 one cycle after accept, no CALC; a=0 b=9 -> result 0
  Both valid continuously, a=255 b=1 / a=5 b=200 -> grants alternate 0,1,0,1 after reset; results 0 and 5
  rsp_ready_i held low 20 cycles in DONE -> outputs stable, both ready_o low, no grant until release
  rst_ni low at CALC iteration 4 -> rsp_valid_o stays 0, next request granted from IDLE to requester 0
  MOD_QUOTIENT_EN build, a=200 b=7 -> rsp_quot_o 28, rsp_result_o 4
